// File: rtl/loba_mult_pipe.sv
// Leading-one-based approximate multiplier, 3-stage valid/ready pipeline with global stall.
// Optional macro LOBA_OPCOUNT_EN adds the 16-bit accepted-output counter op_count.

module loba_split #(
    parameter int N  = 16,
    parameter int W  = 4,
    parameter int KW = $clog2(N)
) (
    input  logic [N-1:0]  x,
    output logic [W-1:0]  xh,
    output logic [KW-1:0] kh,
    output logic [W-1:0]  xl,
    output logic [KW-1:0] kl
);
    localparam logic [N-1:0] SEG_ONES = {{(N-W){1'b0}}, {W{1'b1}}};

    // Low bit position of the W-bit window under the leading one; 0 when the
    // value fits entirely in the bottom window (including zero).
    function automatic int seg_pos(input logic [N-1:0] v);
        int k;
        k = 0;
        for (int i = 0; i < N; i++)
            if (v[i]) k = i;
        return (k >= W-1) ? k - (W-1) : 0;
    endfunction

    always_comb begin
        int ph, pl;
        logic [N-1:0] r;
        ph = seg_pos(x);
        r  = x & ~(SEG_ONES << ph);
        pl = seg_pos(r);
        xh = W'(x >> ph);
        kh = KW'(ph + W - 1);
        xl = W'(r >> pl);
        kl = KW'(pl + W - 1);
    end
endmodule

module loba_mult_pipe #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           mode,
    output logic           out_valid,
    input  logic           out_ready,
`ifdef LOBA_OPCOUNT_EN
    output logic [15:0]    op_count,
`endif
    output logic [2*N-1:0] p
);
    localparam int KW     = $clog2(N);
    localparam int SW     = $clog2(2*N) + 1;
    localparam int STAGES = 3;
    localparam int NT     = 3;   // terms: 0 = Ah*Bh, 1 = Ah*Bl, 2 = Al*Bh

    logic [STAGES:1] vld_pipe;
    logic            stall, adv;

    assign stall     = vld_pipe[STAGES] && !out_ready;
    assign adv       = !stall;
    assign in_ready  = rst_n && !stall;
    assign out_valid = vld_pipe[STAGES];

    // Operand lanes: index 0 = a, 1 = b
    logic [1:0][N-1:0]  op;
    logic [1:0][W-1:0]  seg_h, seg_l;
    logic [1:0][KW-1:0] k_h, k_l;

    assign op = {b, a};

    for (genvar g = 0; g < 2; g++) begin : g_op
        loba_split #(.N(N), .W(W), .KW(KW)) u_split (
            .x  (op[g]),
            .xh (seg_h[g]),
            .kh (k_h[g]),
            .xl (seg_l[g]),
            .kl (k_l[g])
        );
    end

    logic [1:0][W-1:0]  s1_h, s1_l;
    logic [1:0][KW-1:0] s1_kh, s1_kl;
    logic               s1_mode;

    logic [NT-1:0][2*W-1:0] s2_pp;
    logic [NT-1:0][SW-1:0]  s2_sh;

    function automatic logic [SW-1:0] shamt(input logic [KW-1:0] kx, input logic [KW-1:0] ky);
        return SW'(int'(kx) + int'(ky) - 2*(W-1));
    endfunction

    logic [2*N-1:0] sum;

    always_comb begin
        sum = '0;
        for (int t = 0; t < NT; t++)
            sum = sum + ((2*N)'(s2_pp[t]) << s2_sh[t]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_h     <= '0;
            s1_l     <= '0;
            s1_kh    <= '0;
            s1_kl    <= '0;
            s1_mode  <= 1'b0;
            s2_pp    <= '0;
            s2_sh    <= '0;
            p        <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid && in_ready};
            s1_h     <= seg_h;
            s1_l     <= seg_l;
            s1_kh    <= k_h;
            s1_kl    <= k_l;
            s1_mode  <= mode;
            s2_pp[0] <= s1_h[0] * s1_h[1];
            s2_sh[0] <= shamt(s1_kh[0], s1_kh[1]);
            // Cross terms are zeroed in one-term mode so S3 always sums all three.
            s2_pp[1] <= s1_mode ? s1_h[0] * s1_l[1] : '0;
            s2_sh[1] <= shamt(s1_kh[0], s1_kl[1]);
            s2_pp[2] <= s1_mode ? s1_l[0] * s1_h[1] : '0;
            s2_sh[2] <= shamt(s1_kl[0], s1_kh[1]);
            p        <= sum;
        end
    end

`ifdef LOBA_OPCOUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      op_count <= '0;
        else if (out_valid && out_ready) op_count <= op_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_loba_mult_pipe.sv
// Scoreboard bench for loba_mult_pipe: directed vectors, stall stream, random traffic, reset flush.
// Build with LOBA_OPCOUNT_EN defined to also exercise op_count.

module tb_loba_mult_pipe;
    localparam int N = 16;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N-1:0]   a = '0, b = '0;
    logic           mode = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*N-1:0] p;
`ifdef LOBA_OPCOUNT_EN
    logic [15:0]    op_count;
`endif

    loba_mult_pipe #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef LOBA_OPCOUNT_EN
        .op_count  (op_count),
`endif
        .p         (p)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*N-1:0] p;
        int             t;
    } sb_t;

    sb_t            sb[$];
    int             n_cmp = 0, n_err = 0;
    int             cyc_n = 0, acc = 0, opcnt_m = 0;
    bit             chk_lat = 1'b0, was_stall = 1'b0;
    logic [2*N-1:0] held_p = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc_n);
        end
    endtask

    // Reference split: leading one found from the top, residual by subtraction.
    function automatic void msplit(input logic [N-1:0] x, output longint h, output int k,
                                   output logic [N-1:0] r);
        int top;
        top = -1;
        for (int i = N-1; i >= 0; i--)
            if (x[i] && top < 0) top = i;
        if (top < W-1) begin
            h = longint'(x);
            k = W-1;
            r = '0;
        end else begin
            h = longint'(x >> (top-W+1));
            k = top;
            r = x - N'(h << (top-W+1));
        end
    endfunction

    function automatic logic [2*N-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                             input logic m);
        longint xh, xl, yh, yl, t;
        int xk, xlk, yk, ylk;
        logic [N-1:0] xr, yr, rr;
        msplit(x, xh, xk, xr);
        msplit(xr, xl, xlk, rr);
        msplit(y, yh, yk, yr);
        msplit(yr, yl, ylk, rr);
        t = (xh*yh) << (xk + yk - 2*(W-1));
        if (m) t = t + ((xh*yl) << (xk + ylk - 2*(W-1))) + ((xl*yh) << (xlk + yk - 2*(W-1)));
        return (2*N)'(t);
    endfunction

    // One clock: drive at negedge, check the upcoming transfers, score them.
    task automatic cyc(input logic iv, input logic [N-1:0] ia, input logic [N-1:0] ib,
                       input logic im, input logic ordy, input logic [2*N-1:0] exp);
        sb_t e;
        @(negedge clk);
        in_valid = iv; a = ia; b = ib; mode = im; out_ready = ordy;
        #1;
        cyc_n++;
        chk("in_ready", in_ready, rst_n && !(out_valid && !out_ready));
        if (was_stall) begin
            chk("p_hold", p, held_p);
            chk("ov_hold", out_valid, 1'b1);
        end
        was_stall = out_valid && !out_ready;
        held_p    = p;
        if (out_valid && out_ready) begin
            opcnt_m++;
            if (sb.size() == 0) chk("spurious_out", out_valid, 1'b0);
            else begin
                e = sb.pop_front();
                chk("p", p, e.p);
                if (chk_lat) chk("latency", cyc_n - e.t, 3);
            end
        end
        if (iv && in_ready) begin
            sb.push_back('{exp, cyc_n});
            acc++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) cyc(0, '0, '0, 0, 1, '0);
        chk("drain", sb.size(), 0);
    endtask

    task automatic rand_op(input logic ordy_ok);
        logic [N-1:0] x, y;
        logic m;
        x = N'($urandom) >> $urandom_range(0, N-1);
        y = N'($urandom) >> $urandom_range(0, N-1);
        m = 1'($urandom);
        cyc($urandom_range(0, 3) != 0, x, y, m, ordy_ok && ($urandom_range(0, 3) != 0), model(x, y, m));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_p", p, '0);
        chk("rst_in_ready", in_ready, 1'b0);
`ifdef LOBA_OPCOUNT_EN
        chk("rst_op_count", op_count, 16'd0);
`endif
        // Release just after a rising edge; the next edge must accept.
        @(posedge clk); #1 rst_n = 1'b1;
        chk_lat = 1'b1;
        cyc(1, 16'h00FF, 16'h0003, 0, 1, 32'd720);
        cyc(1, 16'h00FF, 16'h0003, 1, 1, 32'd765);
        cyc(1, 16'hFFFF, 16'hFFFF, 0, 1, 32'hE1000000);
        cyc(1, 16'hFFFF, 16'hFFFF, 1, 1, 32'hFD200000);
        cyc(1, 16'h0000, 16'h1234, 0, 1, 32'd0);
        cyc(1, 16'h0000, 16'h1234, 1, 1, 32'd0);
        cyc(1, 16'h0005, 16'h0007, 0, 1, 32'd35);
        cyc(1, 16'h0005, 16'h0007, 1, 1, 32'd35);
        drain();
        chk_lat = 1'b0;

        // 8-op stream with the consumer blocked for cycles 4..6
        acc = 0;
        for (int i = 0; i < 40 && (acc < 8 || sb.size() > 0); i++) begin
            logic [N-1:0] x, y;
            x = N'(16'h1357 * (acc + 1));
            y = N'(16'h0F0F + acc * 16'h0111);
            cyc(acc < 8, x, y, 1'(acc), !(i >= 4 && i <= 6), model(x, y, 1'(acc)));
        end
        chk("stream_count", acc, 8);
        drain();

        repeat (300) rand_op(1'b1);
        drain();
`ifdef LOBA_OPCOUNT_EN
        chk("op_count_rand", op_count, 16'(opcnt_m));
`endif

        // Reset with three operations in flight
        cyc(1, 16'h00FF, 16'h0003, 0, 1, 32'd720);
        cyc(1, 16'hFFFF, 16'hFFFF, 1, 1, 32'hFD200000);
        cyc(1, 16'h0005, 16'h0007, 0, 1, 32'd35);
        #2 rst_n = 1'b0;
        #1;
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b0);
        chk("flush_p", p, '0);
`ifdef LOBA_OPCOUNT_EN
        chk("flush_op_count", op_count, 16'd0);
`endif
        sb.delete();
        opcnt_m = 0;
        was_stall = 1'b0;
        cyc(1, 16'h1111, 16'h2222, 0, 1, '0);
        cyc(1, 16'h1111, 16'h2222, 0, 1, '0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (8) cyc(0, '0, '0, 0, 1, '0);
        chk_lat = 1'b1;
        cyc(1, 16'hFFFF, 16'hFFFF, 0, 1, 32'hE1000000);
        drain();
        chk_lat = 1'b0;

`ifdef LOBA_OPCOUNT_EN
        @(negedge clk) rst_n = 1'b0;
        #1 chk("opc_rst", op_count, 16'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        opcnt_m = 0;
        acc = 0;
        for (int i = 0; i < 65600 && opcnt_m < 65537; i++)
            cyc(acc < 65537, 16'h0003, 16'h0005, 0, 1, 32'd15);
        chk("opc_transfers", opcnt_m, 65537);
        chk("opc_wrap", op_count, 16'd1);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
